// File: rtl/mu_exp_arith_units.sv
// Arithmetic/control leaf for the S0*exp(t*mu) path generator: t*mu fraction multiplier,
// S0*exp scaling multiplier (both two-stage pipelines) and one clear-dominant SR flop.
module mu_exp_arith_units #(
    parameter int unsigned LOGT = 6
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [LOGT:0]   iT,
    input  logic [17:0]     iMu,
    output logic [17:0]     oTMu,
    input  logic [17:0]     iExp,
    input  logic [16:0]     iS,
    output logic [16:0]     oProd,
    input  logic            iSet,
    input  logic            iClr,
    output logic            oQ
);

    logic [LOGT:0] t_q;
    logic [17:0]   mu_q;
    logic [17:0]   exp_q;
    logic [16:0]   s_q;
    logic [17:0]   tmu_q;
    logic [16:0]   prod_q;
    logic          q_q;

    // Only the 18 fraction bits of t*mu are kept, so an 18-bit product is enough.
    logic [17:0]   pa_lo;
    // Bits above 30 of exp*S0 are discarded, so a 31-bit product is enough.
    logic [30:0]   pb_lo;
    logic          unused_pb;

    always_comb begin
        pa_lo = 18'(t_q) * mu_q;
        pb_lo = 31'(exp_q) * 31'(s_q);
    end

    assign unused_pb = ^pb_lo[13:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            t_q    <= '0;
            mu_q   <= '0;
            exp_q  <= '0;
            s_q    <= '0;
            tmu_q  <= '0;
            prod_q <= '0;
            q_q    <= 1'b0;
        end else begin
            t_q    <= iT;
            mu_q   <= iMu;
            exp_q  <= iExp;
            s_q    <= iS;
            tmu_q  <= pa_lo;
            prod_q <= pb_lo[30:14];
            if (iClr) begin
                q_q <= 1'b0;
            end else if (iSet) begin
                q_q <= 1'b1;
            end
        end
    end

    assign oTMu  = tmu_q;
    assign oProd = prod_q;
    assign oQ    = q_q;

endmodule

// File: tb/tb_mu_exp_arith_units.sv
// Scoreboard bench for mu_exp_arith_units: expected products are queued when operands are
// driven and compared two edges later; the SR flop is tracked by a next-state model.
module tb_mu_exp_arith_units;

    localparam int unsigned LOGT = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic [LOGT:0] iT;
    logic [17:0]   iMu;
    logic [17:0]   oTMu;
    logic [17:0]   iExp;
    logic [16:0]   iS;
    logic [16:0]   oProd;
    logic          iSet;
    logic          iClr;
    logic          oQ;

    mu_exp_arith_units #(.LOGT(LOGT)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .iT    (iT),
        .iMu   (iMu),
        .oTMu  (oTMu),
        .iExp  (iExp),
        .iS    (iS),
        .oProd (oProd),
        .iSet  (iSet),
        .iClr  (iClr),
        .oQ    (oQ)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [17:0] tmu;
        logic [16:0] prod;
    } exp_t;

    exp_t        sb_q[$];
    logic        q_exp = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [17:0] model_tmu(input logic [LOGT:0] t, input logic [17:0] mu);
        logic [24:0] pa;
        pa = 25'(t) * 25'(mu);
        return pa[17:0];
    endfunction

    function automatic logic [16:0] model_prod(input logic [17:0] e, input logic [16:0] s);
        logic [34:0] pb;
        pb = 35'(e) * 35'(s);
        return pb[30:14];
    endfunction

    // One clock: drive, push expectation, wait for the edge, then pop and compare.
    task automatic cycle(input logic rst, input logic [LOGT:0] t, input logic [17:0] mu,
                         input logic [17:0] e, input logic [16:0] s,
                         input logic set, input logic clr,
                         input logic [17:0] exp_tmu, input logic [16:0] exp_prod);
        exp_t ent;
        RST  = rst;
        iT   = t;
        iMu  = mu;
        iExp = e;
        iS   = s;
        iSet = set;
        iClr = clr;
        if (rst) begin
            sb_q.delete();
            sb_q.push_back('0);
            sb_q.push_back('0);
            q_exp = 1'b0;
        end else begin
            ent.tmu  = exp_tmu;
            ent.prod = exp_prod;
            sb_q.push_back(ent);
            if (clr) q_exp = 1'b0;
            else if (set) q_exp = 1'b1;
        end
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            ent = sb_q.pop_front();
            check("oTMu", 32'(oTMu), 32'(ent.tmu));
            check("oProd", 32'(oProd), 32'(ent.prod));
        end
        check("oQ", 32'(oQ), 32'(q_exp));
    endtask

    task automatic modeled(input logic rst, input logic [LOGT:0] t, input logic [17:0] mu,
                           input logic [17:0] e, input logic [16:0] s,
                           input logic set, input logic clr);
        cycle(rst, t, mu, e, s, set, clr, model_tmu(t, mu), model_prod(e, s));
    endtask

    initial begin
        int unsigned high_cnt;
        RST = 1'b1; iT = '0; iMu = '0; iExp = '0; iS = '0; iSet = 1'b0; iClr = 1'b0;

        // Reset with live operands and set asserted: everything stays zero.
        cycle(1'b1, 7'd5, 18'h12345, 18'h3ABCD, 17'h1F00F, 1'b1, 1'b0, 18'h0, 17'h0);
        cycle(1'b1, 7'd9, 18'h3FFFF, 18'h3FFFF, 17'h1FFFF, 1'b1, 1'b0, 18'h0, 17'h0);
        check("reset_oQ", 32'(oQ), 32'd0);

        // Directed multiplier vectors with literal expectations.
        cycle(1'b0, 7'd3, 18'h01000, 18'h04000, 17'h01000, 1'b0, 1'b0, 18'h03000, 17'h01000);
        cycle(1'b0, 7'd64, 18'h01000, 18'h3FFFF, 17'h1FFFF, 1'b0, 1'b0, 18'h00000, 17'h1FFE8);
        cycle(1'b0, 7'd0, 18'h0, 18'h0, 17'h0, 1'b0, 1'b0, 18'h0, 17'h0);
        cycle(1'b0, 7'd0, 18'h0, 18'h0, 17'h0, 1'b0, 1'b0, 18'h0, 17'h0);

        // Back-to-back stream, no bubbles.
        for (int t = 0; t < 64; t++) begin
            cycle(1'b0, 7'(t), 18'h00100, 18'h04000, 17'(t), 1'b0, 1'b0,
                  18'(t * 32'h100), 17'(t));
        end

        // SR flop: set holds, set+clear clears.
        modeled(1'b0, 7'd1, 18'h1, 18'h1, 17'h1, 1'b1, 1'b0);
        check("sr_set", 32'(oQ), 32'd1);
        modeled(1'b0, 7'd1, 18'h1, 18'h1, 17'h1, 1'b0, 1'b0);
        check("sr_hold", 32'(oQ), 32'd1);
        modeled(1'b0, 7'd1, 18'h1, 18'h1, 17'h1, 1'b1, 1'b1);
        check("sr_clr_dominant", 32'(oQ), 32'd0);

        // Self-clearing pulse: iClr follows oQ.
        high_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            modeled(1'b0, 7'd2, 18'h2, 18'h2, 17'h2, (i == 0), oQ);
            if (oQ) high_cnt++;
        end
        check("sr_pulse_width", high_cnt, 32'd1);

        // Reset mid-stream flushes both pipelines.
        modeled(1'b0, 7'd7, 18'h3FFFF, 18'h3FFFF, 17'h1FFFF, 1'b1, 1'b0);
        modeled(1'b1, 7'd7, 18'h3FFFF, 18'h3FFFF, 17'h1FFFF, 1'b0, 1'b0);
        modeled(1'b0, 7'd5, 18'h20000, 18'h3FFFF, 17'h1FFFF, 1'b0, 1'b0);
        modeled(1'b0, 7'd0, 18'h0, 18'h0, 17'h0, 1'b0, 1'b0);
        modeled(1'b0, 7'd0, 18'h0, 18'h0, 17'h0, 1'b0, 1'b0);

        // Random operands with occasional resets and random SR requests.
        for (int i = 0; i < 10000; i++) begin
            modeled(($urandom_range(99) < 2),
                    7'($urandom_range(64)),
                    18'($urandom),
                    18'($urandom),
                    17'($urandom),
                    ($urandom_range(3) == 0),
                    ($urandom_range(3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
